// File: rtl/riscv_uop_pkg.sv
// riscv_uop_pkg: shared micro-op types for the execute stages.
// Load/store FSM states, funct3 size codes and the captured LSU op.
package riscv_uop_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef struct packed {
    logic                is_store;
    logic [2:0]          funct3;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
    logic [4:0]          rd;
  } lsu_op_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering shared by loads and stores.
// Byte enables, store lane replication/shift, load extract/extend.
module lsu_align
  import riscv_uop_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          off,
  input  logic [LSU_XLEN-1:0] wdata,
  input  logic [LSU_XLEN-1:0] rdata,
  output logic [3:0]          be,
  output logic [LSU_XLEN-1:0] wdata_sh,
  output logic [LSU_XLEN-1:0] rdata_ext
);

  logic                is_b;
  logic                is_h;
  logic                uns;
  logic [LSU_XLEN-1:0] wrep;
  logic [LSU_XLEN-1:0] rsh;

  assign is_b = funct3 inside {LSU_LB, LSU_LBU, LSU_SB};
  assign is_h = funct3 inside {LSU_LH, LSU_LHU};
  assign uns  = funct3 inside {LSU_LBU, LSU_LHU};
  assign rsh  = rdata >> {off, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wrep      = wdata;
    rdata_ext = rdata;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << off;
        wrep      = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'b0, rsh[7:0]}
                        : {{24{rsh[7]}}, rsh[7:0]};
      end
      is_h: begin
        be        = 4'b0011 << off;
        wrep      = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'b0, rsh[15:0]}
                        : {{16{rsh[15]}}, rsh[15:0]};
      end
      default: ;
    endcase
  end

  assign wdata_sh = wrep << {off, 3'b000};

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store execute stage, one memory op in flight.
// LSU_MISALIGN_TRAP_EN: misaligned ops fault instead of force-aligning.
module lsu_stage
  import riscv_uop_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_base,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_valid,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_result,
  output logic            o_fault
);

  lsu_state_e      state_q, state_d;
  lsu_op_t         op_q, op_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            kill_q, kill_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] ea_fix;
  logic            is_h;
  logic            is_w;
  logic            trap;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] ld_ext;

  assign is_h = i_funct3 inside {LSU_LH, LSU_LHU, LSU_SH};
  assign is_w = i_funct3 inside {LSU_LW, LSU_SW};

  always_comb begin
    ea     = i_base + i_imm;
    ea_fix = ea;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ALIGN_CHECK &&
      ((is_h && ea[0]) ||
       (is_w && ea[1:0] != 2'b00));
`else
    trap = 1'b0;
    if (is_h) ea_fix[0]   = 1'b0;
    if (is_w) ea_fix[1:0] = 2'b00;
`endif
  end

`ifndef LSU_MISALIGN_TRAP_EN
  logic unused_align_check;
  assign unused_align_check = ALIGN_CHECK;
`endif

  lsu_align u_align (
    .funct3    (op_q.funct3),
    .off       (op_q.addr[1:0]),
    .wdata     (op_q.wdata),
    .rdata     (rdata_q),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rdata_d     = rdata_q;
    kill_d      = kill_q;
    fault_d     = fault_q;
    o_ready     = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = 4'b0000;
    o_valid     = 1'b0;
    o_wb_en     = 1'b0;
    o_wb_rd     = 5'd0;
    o_result    = '0;
    o_fault     = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        kill_d  = 1'b0;
        fault_d = 1'b0;
        if (i_valid && !i_flush) begin
          op_d = '{is_store: i_is_store,
                   funct3:   i_funct3,
                   addr:     ea_fix,
                   wdata:    i_wdata,
                   rd:       i_rd};
          fault_d = trap;
          state_d = trap ? DONE : REQ;
        end
      end
      REQ: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          o_mem_req   = 1'b1;
          o_mem_we    = op_q.is_store;
          o_mem_addr  = {op_q.addr[XLEN-1:2], 2'b00};
          o_mem_wdata = wdata_sh;
          o_mem_be    = be;
          if (i_mem_gnt) begin
            // zero-latency memory answers in the grant cycle
            if (i_mem_rvalid) begin
              rdata_d = i_mem_rdata;
              state_d = DONE;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (i_flush) kill_d = 1'b1;
        if (i_mem_rvalid) begin
          rdata_d = i_mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        o_valid = !kill_q && !i_flush;
        o_fault = o_valid && fault_q;
        o_wb_en = o_valid && !op_q.is_store &&
                  (op_q.rd != 5'd0) && !fault_q;
        o_wb_rd = o_valid ? op_q.rd : 5'd0;
        if (o_valid) begin
          if (fault_q)               o_result = op_q.addr;
          else if (!op_q.is_store)   o_result = ld_ext;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rdata_q <= '0;
      kill_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      kill_q  <= kill_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store execution stage, directly downstream of issue_stage on the lsu_issue_if path.
- Parallel to alu_stage; feeds retire with load results.
- Computes the effective address and drives a single-outstanding data-memory request/response port.
- Sign/zero-extends load data, then presents one retire beat per memory op.

Parameters:
- XLEN, 32, data/address width.
- ALIGN_CHECK, 1, 1 = misaligned accesses are detected (see Behaviour); 0 = check disabled.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_valid  in  1  issue presents op
- o_ready  out  1  LSU can accept op
- i_is_store  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- i_base  in  XLEN  rs1 value
- i_imm  in  XLEN  sign-extended offset
- i_wdata  in  XLEN  rs2 value
- i_rd  in  5  load destination
- i_flush  in  1  kill op not yet sent to memory
- o_mem_req  out  1  memory request valid
- i_mem_gnt  in  1  memory accepts request
- o_mem_we  out  1  write enable
- o_mem_addr  out  XLEN  word-aligned address
- o_mem_wdata  out  XLEN  lane-shifted store data
- o_mem_be  out  4  byte enables
- i_mem_rvalid  in  1  response valid
- i_mem_rdata  in  XLEN  read data
- o_valid  out  1  retire beat, one cycle
- o_wb_en  out  1  register write (load, rd != 0, no fault)
- o_wb_rd  out  5  destination
- o_result  out  XLEN  extended load data
- o_fault  out  1  misaligned-access indication

Behaviour:
- Reset is synchronous, active-low.
  - FSM goes to IDLE.
  - Outputs are 0, except o_ready = 1.
- Address and lanes:
  - addr = i_base + i_imm, modulo 2^XLEN; wrap-around is ignored.
  - o_mem_addr = {addr[XLEN-1:2], 2'b00}.
  - Byte enables: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
  - Store data: wdata replicated per size, then shifted by 8*addr[1:0].
- FSM state IDLE:
  - o_ready = 1.
  - i_valid && !i_flush: capture op → REQ.
  - Misaligned op (half with addr[0] = 1, word with addr[1:0] != 0) and ALIGN_CHECK = 1 → DONE with fault; memory is not accessed.
- FSM state REQ:
  - o_mem_req = 1; outputs held stable until i_mem_gnt.
  - Grant → WAIT.
  - Grant and i_mem_rvalid in the same cycle (zero-latency memory) → DONE.
  - i_flush before grant → IDLE; no request is issued that cycle.
- FSM state WAIT:
  - Waits for i_mem_rvalid; captures rdata.
  - Store: proceeds on rvalid (write acknowledge).
  - i_flush during WAIT sets a kill flag; the response is still consumed.
- FSM state DONE:
  - o_valid = 1 for exactly one cycle, unless killed.
  - A load sets o_wb_en = (rd != 0) && !fault; a store sets o_wb_en = 0.
  - → IDLE.
- Load extension:
  - Byte/half selected by addr[1:0] / addr[1].
  - Sign-extended for LB/LH, zero-extended for LBU/LHU.
- Timing:
  - Minimum latency from accept to o_valid is 2 cycles with gnt and rvalid in the same cycle.
  - One op is in flight; o_ready = 0 outside IDLE.
  - A flush arriving in the DONE cycle suppresses o_valid.
- Response with no request pending: ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned op raises o_fault with o_valid.
  - o_result carries the faulting address.
  - No memory access.
- Undefined:
  - o_fault is tied to 0.
  - Misaligned ops are force-aligned (addr[0] cleared for half, addr[1:0] cleared for word) and proceed normally.
  - ALIGN_CHECK has no effect.

Decomposition:
- riscv_uop_pkg holds:
  - lsu_state_e (IDLE, REQ, WAIT, DONE).
  - funct3 constants (LSU_LB … LSU_SW).
  - lsu_op_t: the captured op struct (is_store, funct3, addr, wdata, rd).
- One sub-module: lsu_align.
  - Purely combinational.
  - Computes byte enables, store lane shift, and load extraction/extension.
  - Shared by load and store paths.

Test Plan:
- LW: base 0x100, imm 4, mem[0x104] = 0xDEADBEEF, gnt + rvalid next cycle → mem_addr 0x104, be 4'b1111, o_result 0xDEADBEEF, wb_rd = rd, wb_en = 1.
- LB / LBU at 0x103, word 0x80xxxxxx → LB result 0xFFFFFF80, LBU result 0x00000080; be 4'b1000.
- SH rs2 = 0x1234ABCD at 0x102 → mem_we = 1, be 4'b1100, wdata 0xABCD0000; o_valid with wb_en = 0.
- LW at 0x102 with macro defined → no o_mem_req, o_fault = 1, o_result 0x102. Without macro → mem_addr 0x100, normal load.
- Flush in REQ before gnt → no o_valid, o_ready = 1 next cycle. Flush in WAIT → response consumed, no o_valid.
- gnt held low 5 cycles → req/addr/be/wdata stable throughout. rst_n low mid-WAIT → IDLE, o_valid = 0, later rvalid ignored.
